// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder: SLC-3 SRAM-bus responder backed by an on-chip word RAM, plus a sequential program-load port.
// Latency: reads appear READ_LATENCY edges after OE is sampled low; writes commit on the first edge WE is seen low.
// Backpressure: none on the CPU side (accesses ignored while Busy); load port takes one word per cycle while Load_Ready.
// Optional feature: define MEM_ACCESS_COUNT_EN to add saturating Read_Count/Write_Count outputs.
module slc3_mem_responder #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  input  logic        Load_Start,
  input  logic        Load_Valid,
  input  logic [15:0] Load_Data,
  output logic        Load_Ready,
  output logic        Load_Done,
  output logic        Busy
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] Read_Count,
  output logic [15:0] Write_Count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  // Pipeline stages between the RAM read and the output register (at least one slot declared).
  localparam int PS    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  typedef enum logic {SERVE, LOAD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cpu_addr;
  logic              we_prev;
  logic [15:0]       mem [DEPTH];
  logic [PS-1:0]     pipe_vld;
  logic [15:0]       pipe_dat [PS];
  logic              serve;
  logic              enter_load;
  logic              cpu_wr;
  logic              rd_issue;
  logic              ld_wr;
  logic [15:0]       rd_dat;
  logic              out_vld;
  logic [15:0]       out_dat;
  logic              unused_addr_hi;

  // Upper address bits are ignored so CPU addresses wrap modulo the RAM depth.
  assign cpu_addr       = ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^ADDR[15:ADDR_W];

  // Load_Start preempts any CPU access sampled on the same edge.
  assign enter_load = (state == SERVE) && Load_Start;
  assign serve      = (state == SERVE) && !Load_Start;
  // WE=0 always wins over OE=0: a write cycle never issues a read.
  assign cpu_wr     = serve && !WE && we_prev;
  assign rd_issue   = serve && !OE && WE;
  assign ld_wr      = (state == LOAD) && !Load_Start && Load_Valid;
  assign rd_dat     = mem[cpu_addr];

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign out_vld = rd_issue;
      assign out_dat = rd_dat;
    end else begin : g_latn
      assign out_vld = pipe_vld[PS-1];
      assign out_dat = pipe_dat[PS-1];
    end
  endgenerate

  // Single shared write port; contents deliberately survive Reset.
  always_ff @(posedge Clk) begin
    if (!Reset && cpu_wr) begin
      mem[cpu_addr] <= Data_to_SRAM;
    end else if (!Reset && ld_wr) begin
      mem[ptr] <= Load_Data;
    end
  end

  // Read pipeline: data captured at the sample edge, valid flags flushed on reset and on entering LOAD.
  always_ff @(posedge Clk) begin
    if (Reset || enter_load) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      for (int i = 1; i < PS; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
    pipe_dat[0] <= rd_dat;
    for (int i = 1; i < PS; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  // Mode FSM with registered status outputs, load pointer and WE edge history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= SERVE;
      ptr            <= '0;
      we_prev        <= 1'b1;
      Data_from_SRAM <= 16'h0000;
      Load_Ready     <= 1'b0;
      Load_Done      <= 1'b0;
      Busy           <= 1'b0;
    end else begin
      we_prev   <= WE;
      Load_Done <= 1'b0;
      case (state)
        SERVE: begin
          if (Load_Start) begin
            state          <= LOAD;
            ptr            <= '0;
            Data_from_SRAM <= 16'h0000;
            Load_Ready     <= 1'b1;
            Busy           <= 1'b1;
          end else if (out_vld) begin
            Data_from_SRAM <= out_dat;
          end
        end
        LOAD: begin
          // Exit on an explicit stop or after the last address is written; no second pass.
          if (Load_Start || (Load_Valid && (ptr == '1))) begin
            state      <= SERVE;
            ptr        <= '0;
            Load_Ready <= 1'b0;
            Busy       <= 1'b0;
            Load_Done  <= 1'b1;
          end else if (Load_Valid) begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Saturating counts of CPU reads issued and writes committed while serving.
  always_ff @(posedge Clk) begin
    if (Reset || enter_load) begin
      Read_Count  <= 16'h0000;
      Write_Count <= 16'h0000;
    end else begin
      if (rd_issue && (Read_Count != 16'hFFFF)) Read_Count <= Read_Count + 16'd1;
      if (cpu_wr && (Write_Count != 16'hFFFF)) Write_Count <= Write_Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: directed vector table, hand-written load sequences,
// then randomized traffic compared against a queue-based behavioural model.
module tb_slc3_mem_responder;

  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int DEP = 1 << AW;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] ADDR = 16'h0000;
  logic        OE = 1'b1;
  logic        WE = 1'b1;
  logic [15:0] Data_to_SRAM = 16'h0000;
  logic [15:0] Data_from_SRAM;
  logic        Load_Start = 1'b0;
  logic        Load_Valid = 1'b0;
  logic [15:0] Load_Data = 16'h0000;
  logic        Load_Ready;
  logic        Load_Done;
  logic        Busy;
`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] Read_Count;
  logic [15:0] Write_Count;
`endif

  slc3_mem_responder #(.ADDR_W(AW), .READ_LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
    .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Load_Start(Load_Start), .Load_Valid(Load_Valid), .Load_Data(Load_Data),
    .Load_Ready(Load_Ready), .Load_Done(Load_Done), .Busy(Busy)
`ifdef MEM_ACCESS_COUNT_EN
    , .Read_Count(Read_Count), .Write_Count(Write_Count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [15:0] val;
  } rd_t;

  logic [15:0] m_mem [DEP];
  rd_t         m_q[$];
  bit          m_load = 1'b0;
  int          m_ptr = 0;
  bit          m_weh = 1'b1;
  logic [15:0] m_out = 16'h0000;
  bit          m_done = 1'b0;
  int          m_rc = 0;
  int          m_wc = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model(input bit rst, input bit oe, input bit we, input logic [15:0] addr,
                       input logic [15:0] din, input bit ls, input bit lv, input logic [15:0] ld);
    rd_t r;
    cyc++;
    if (rst) begin
      m_load = 1'b0; m_ptr = 0; m_q.delete(); m_out = 16'h0000;
      m_done = 1'b0; m_weh = 1'b1; m_rc = 0; m_wc = 0;
    end else begin
      m_done = 1'b0;
      if (!m_load) begin
        if (ls) begin
          m_load = 1'b1; m_ptr = 0; m_q.delete(); m_out = 16'h0000; m_rc = 0; m_wc = 0;
        end else if (!we && m_weh) begin
          m_mem[addr % DEP] = din;
          if (m_wc < 65535) m_wc++;
        end else if (!oe && we) begin
          r.due = cyc + LAT - 1;
          r.val = m_mem[addr % DEP];
          m_q.push_back(r);
          if (m_rc < 65535) m_rc++;
        end
      end else begin
        if (ls) begin
          m_load = 1'b0; m_done = 1'b1;
        end else if (lv) begin
          m_mem[m_ptr] = ld;
          if (m_ptr == DEP - 1) begin
            m_load = 1'b0; m_done = 1'b1; m_ptr = 0;
          end else begin
            m_ptr++;
          end
        end
      end
      m_weh = we;
    end
    while (m_q.size() > 0 && m_q[0].due <= cyc) begin
      m_out = m_q[0].val;
      m_q.delete(0);
    end
  endtask

  // One clock: drive at negedge, let the edge happen, update model, sample #1 later.
  task automatic step(input bit rst, input bit oe, input bit we, input logic [15:0] addr,
                      input logic [15:0] din, input bit ls, input bit lv, input logic [15:0] ld);
    @(negedge Clk);
    Reset = rst; OE = oe; WE = we; ADDR = addr; Data_to_SRAM = din;
    Load_Start = ls; Load_Valid = lv; Load_Data = ld;
    @(posedge Clk);
    #1;
    model(rst, oe, we, addr, din, ls, lv, ld);
    chk("model_dout", Data_from_SRAM, m_out);
    chk("model_busy", {15'd0, Busy}, {15'd0, m_load});
    chk("model_ready", {15'd0, Load_Ready}, {15'd0, m_load});
    chk("model_done", {15'd0, Load_Done}, {15'd0, m_done});
`ifdef MEM_ACCESS_COUNT_EN
    chk("model_rd_count", Read_Count, m_rc[15:0]);
    chk("model_wr_count", Write_Count, m_wc[15:0]);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst, oe, we;
    logic [15:0] addr, din;
    bit          ls, lv;
    logic [15:0] ld;
    logic [15:0] e_dout;
    bit          e_busy, e_done;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t v(input bit rst, input bit oe, input bit we, input logic [15:0] addr,
                             input logic [15:0] din, input bit ls, input bit lv, input logic [15:0] ld,
                             input logic [15:0] e_dout, input bit e_busy, input bit e_done);
    vec_t t;
    t.rst = rst; t.oe = oe; t.we = we; t.addr = addr; t.din = din;
    t.ls = ls; t.lv = lv; t.ld = ld; t.e_dout = e_dout; t.e_busy = e_busy; t.e_done = e_done;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    logic [15:0] words [DEP];
    bit r_rst, r_oe, r_we, r_ls, r_lv;

    //            rst oe we addr      din       ls lv ld        dout      busy done
    tbl[0]  = v(1, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[1]  = v(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0);
    tbl[2]  = v(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 16'h1111, 16'h0000, 1, 0);
    tbl[3]  = v(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 16'h2222, 16'h0000, 1, 0);
    tbl[4]  = v(0, 1, 1, 16'h0000, 16'h0000, 0, 1, 16'h3333, 16'h0000, 1, 0);
    tbl[5]  = v(0, 1, 0, 16'h0009, 16'hABCD, 0, 1, 16'h4444, 16'h0000, 1, 0);
    tbl[6]  = v(0, 1, 1, 16'h0000, 16'h0000, 1, 1, 16'hDEAD, 16'h0000, 0, 1);
    tbl[7]  = v(0, 0, 1, 16'h0003, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[8]  = v(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h4444, 0, 0);
    tbl[9]  = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h1111, 0, 0);
    tbl[10] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h1111, 0, 0);
    tbl[11] = v(1, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[12] = v(0, 0, 1, 16'h0012, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[13] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h3333, 0, 0);
    tbl[14] = v(0, 1, 0, 16'h0005, 16'h1234, 0, 0, 16'h0000, 16'h3333, 0, 0);
    tbl[15] = v(0, 1, 0, 16'h0005, 16'hFFFF, 0, 0, 16'h0000, 16'h3333, 0, 0);
    tbl[16] = v(0, 1, 0, 16'h0005, 16'hFFFF, 0, 0, 16'h0000, 16'h3333, 0, 0);
    tbl[17] = v(0, 0, 1, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h3333, 0, 0);
    tbl[18] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
    tbl[19] = v(0, 0, 0, 16'h0007, 16'hBEEF, 0, 0, 16'h0000, 16'h1234, 0, 0);
    tbl[20] = v(0, 0, 1, 16'h0007, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
    tbl[21] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'hBEEF, 0, 0);
    tbl[22] = v(0, 1, 0, 16'h0006, 16'h0A0A, 0, 0, 16'h0000, 16'hBEEF, 0, 0);
    tbl[23] = v(0, 0, 1, 16'h0006, 16'h0000, 0, 0, 16'h0000, 16'hBEEF, 0, 0);
    tbl[24] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0A0A, 0, 0);
    tbl[25] = v(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0);
    tbl[26] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 1, 16'hAAAA, 16'h0000, 1, 0);
    tbl[27] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 1, 16'hBBBB, 16'h0000, 1, 0);
    tbl[28] = v(1, 1, 1, 16'h0000, 16'h0000, 0, 1, 16'hCCCC, 16'h0000, 0, 0);
    tbl[29] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[30] = v(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[31] = v(0, 0, 1, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'hAAAA, 0, 0);
    tbl[32] = v(0, 0, 1, 16'h0002, 16'h0000, 0, 0, 16'h0000, 16'hBBBB, 0, 0);
    tbl[33] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h3333, 0, 0);

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].rst, tbl[i].oe, tbl[i].we, tbl[i].addr, tbl[i].din,
           tbl[i].ls, tbl[i].lv, tbl[i].ld);
      chk($sformatf("vec%0d_dout", i), Data_from_SRAM, tbl[i].e_dout);
      chk($sformatf("vec%0d_busy", i), {15'd0, Busy}, {15'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d_done", i), {15'd0, Load_Done}, {15'd0, tbl[i].e_done});
    end

    // Full-depth load: auto exit after the last address, no wrap into a second pass.
    step(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 16'h0000);
    for (int k = 0; k < DEP; k++) begin
      words[k] = 16'($urandom);
      step(0, 1, 1, 16'h0000, 16'h0000, 0, 1, words[k]);
      if (k < DEP - 1) begin
        chk("full_load_busy", {15'd0, Busy}, 16'd1);
      end else begin
        chk("full_load_autoexit_done", {15'd0, Load_Done}, 16'd1);
        chk("full_load_autoexit_ready", {15'd0, Load_Ready}, 16'd0);
      end
    end
    step(0, 1, 1, 16'h0000, 16'h0000, 0, 1, 16'hFFFF);
    chk("done_single_pulse", {15'd0, Load_Done}, 16'd0);
    step(0, 0, 1, 16'h0013, 16'h0000, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    chk("wrap_read_0x13", Data_from_SRAM, words[3]);
    step(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    chk("no_second_pass_mem0", Data_from_SRAM, words[0]);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r_rst = ($urandom % 150) == 0;
      r_oe  = ($urandom % 3) == 0;
      r_we  = ($urandom % 4) != 0;
      r_ls  = ($urandom % 40) == 0;
      r_lv  = ($urandom % 4) != 0;
      step(r_rst, r_oe, r_we, 16'($urandom), 16'($urandom), r_ls, r_lv, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
